fetch_stage: RTL

Instruction fetch stage and IF/ID pipeline register of the pipelined RISC core. Holds the program counter, drives the instruction memory address, and registers the fetched word with its PC. Also slices the registered word into opcode, Rd, Rs, Rt and 14-bit immediate fields for the decode stage. The downstream immediate extender and register file consume `id_opcode`/`id_imm` and the register fields directly.

---
 rtl/fetch_stage.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register and decode field slicing.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus1,
   output logic [5:0]  id_opcode,
   output logic [3:0]  id_rd,
   output logic [3:0]  id_rs,
   output logic [3:0]  id_rt,
   output logic [13:0] id_imm,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stalls
);

   typedef enum logic {
      ST_RESET = 1'b0,
      ST_RUN   = 1'b1
   } run_state_t;

   typedef enum logic [2:0] {
      ACT_IDLE,
      ACT_REDIRECT,
      ACT_HOLD,
      ACT_HOLD_FLUSH,
      ACT_FLUSH,
      ACT_FETCH
   } action_t;

   run_state_t  run_state;
   action_t     action;

   logic [31:0] pc_q,        pc_d;
   logic        valid_q,     valid_d;
   logic [31:0] instr_q,     instr_d;
   logic [31:0] id_pc_q,     id_pc_d;
   logic [31:0] id_pc_p1_q,  id_pc_p1_d;
   logic [31:0] pc_plus1;
   logic        load_valid;
   logic        stall_cycle;

   // Run control follows reset directly so the first fetch happens in the
   // very first cycle after reset is released.
   assign run_state = reset ? ST_RESET : ST_RUN;
   assign pc_plus1  = pc_q + 32'd1;

   always_comb begin
      action = ACT_IDLE;
      case (run_state)
         ST_RESET: action = ACT_IDLE;
         ST_RUN: begin
            if (redirect)
               action = ACT_REDIRECT;
            else if (stall && flush)
               action = ACT_HOLD_FLUSH;
            else if (stall)
               action = ACT_HOLD;
            else if (flush)
               action = ACT_FLUSH;
            else
               action = ACT_FETCH;
         end
         default: action = ACT_IDLE;
      endcase
   end

   always_comb begin
      pc_d       = pc_q;
      valid_d    = valid_q;
      instr_d    = instr_q;
      id_pc_d    = id_pc_q;
      id_pc_p1_d = id_pc_p1_q;
      case (action)
         ACT_REDIRECT: begin
            pc_d       = redirect_pc;
            valid_d    = 1'b0;
            instr_d    = 32'h0;
            id_pc_d    = 32'h0;
            id_pc_p1_d = 32'h0;
         end
         ACT_HOLD_FLUSH: begin
            valid_d    = 1'b0;
            instr_d    = 32'h0;
            id_pc_d    = 32'h0;
            id_pc_p1_d = 32'h0;
         end
         ACT_FLUSH: begin
            pc_d       = pc_plus1;
            valid_d    = 1'b0;
            instr_d    = 32'h0;
            id_pc_d    = 32'h0;
            id_pc_p1_d = 32'h0;
         end
         ACT_FETCH: begin
            pc_d       = pc_plus1;
            valid_d    = 1'b1;
            instr_d    = imem_data;
            id_pc_d    = pc_q;
            id_pc_p1_d = pc_plus1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         valid_q    <= 1'b0;
         instr_q    <= 32'h0;
         id_pc_q    <= 32'h0;
         id_pc_p1_q <= 32'h0;
      end else begin
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         id_pc_q    <= id_pc_d;
         id_pc_p1_q <= id_pc_p1_d;
      end
   end

   assign load_valid  = (action == ACT_FETCH);
   assign stall_cycle = (action == ACT_HOLD) || (action == ACT_HOLD_FLUSH);

`ifdef FETCH_PERF_EN
   logic [31:0] fetched_q, fetched_d;
   logic [31:0] stalls_q,  stalls_d;

   // Saturating counters: stick at all-ones rather than wrapping.
   always_comb begin
      fetched_d = fetched_q;
      stalls_d  = stalls_q;
      if (load_valid && (fetched_q != 32'hFFFF_FFFF))
         fetched_d = fetched_q + 32'd1;
      if (stall_cycle && (stalls_q != 32'hFFFF_FFFF))
         stalls_d = stalls_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetched_q <= 32'h0;
         stalls_q  <= 32'h0;
      end else begin
         fetched_q <= fetched_d;
         stalls_q  <= stalls_d;
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_stalls  = stalls_q;
`else
   logic unused_perf;
   assign unused_perf  = load_valid ^ stall_cycle;
   assign perf_fetched = 32'h0;
   assign perf_stalls  = 32'h0;
`endif

   assign imem_addr   = pc_q;
   assign id_valid    = valid_q;
   assign id_instr    = instr_q;
   assign id_pc       = id_pc_q;
   assign id_pc_plus1 = id_pc_p1_q;
   assign id_opcode   = instr_q[31:26];
   assign id_rd       = instr_q[25:22];
   assign id_rs       = instr_q[21:18];
   assign id_rt       = instr_q[17:14];
   assign id_imm      = instr_q[13:0];

endmodule
